wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back end of the MEM/WB pipeline interface. Consumes the registered W-stage bundle, selects the write-back value by `regSrc_muxW`, and commits it into a 32×32 general register file. Provides two decode-stage read ports with same-cycle write-first bypass and a committed-write counter with a registered trace port for the verification bench.

## Interface
Parameters:
- `NREGS`, 32: number of architectural registers. Register 0 is hardwired to zero.
- `TRACE_EN`, 1: when 0, the trace outputs are tied to their reset values.

Ports (clock and reset first):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `Regfile_weW`  in  1  W-stage write enable.
- `regSrc_muxW`  in  `REG_SRC_LENGTH` (2)  write-back source select.
- `aluOutW`  in  `WORD_WIDTH` (32)  ALU result.
- `readDataW`  in  32  load data.
- `jal_targetW`  in  32  link value for jal/jalr.
- `writeRegAddrW`  in  `REG_SIZE` (5)  destination register.
- `rs_addrD`, `rt_addrD`  in  5 each  decode read addresses.
- `rs_dataD`, `rt_dataD`  out  32 each  read data (combinational).
- `wb_dataW`  out  32  selected write-back value (combinational), used by forwarding.
- `commitW`  out  1  the current W-stage entry writes a register this cycle (combinational).
- `instret`  out  32  count of committed writes.
- `trace_we`, `trace_addr`(5), `trace_data`(32)  out  registered copy of the last commit.

## Operation
- Source encoding: 00 selects `aluOutW`; 01 selects `readDataW`; 10 selects `jal_targetW`; 11 is reserved. With 11, `wb_dataW` = 0 and the write is suppressed.
- `commitW` = `Regfile_weW` & (`writeRegAddrW` != 0) & (`regSrc_muxW` != 11).
- When `commitW` is 1, register[`writeRegAddrW`] is updated with `wb_dataW` at the rising edge.
- A write with address 0 is discarded. Register 0 always reads 0.
- Read ports:
  - Address 0 returns 0.
  - If the read address equals `writeRegAddrW` and `commitW` is 1, the port returns `wb_dataW` (write-first bypass).
  - Otherwise the port returns the stored value.
- Both ports bypass independently. If rs equals rt, both ports return the same value.
- `instret` increments by 1 per `commitW` cycle. It wraps from 0xFFFFFFFF to 0 without a flag.
- Trace registers load `commitW`, `writeRegAddrW` and `wb_dataW` every cycle. `trace_we` = 0 on non-commit cycles, and `trace_addr`/`trace_data` then hold their previous values.

## Timing
- Read path and `wb_dataW`: zero-cycle combinational.
- A value written at edge N is visible from storage after edge N and via bypass during the cycle before edge N. Decode therefore needs no extra stall for a W-stage producer.
- Trace and `instret` lag the commit by one edge.
- Reset values (asynchronous, immediate on `rst` low):
  - All registers are 0.
  - `instret` is 0.
  - `trace_we` is 0, `trace_addr` is 0, `trace_data` is 0.
  - Combinational outputs follow from cleared storage.
- Reset asserted mid-operation: an in-flight write is discarded and no partial update occurs.
- First edge after `rst` deasserts: normal commit is allowed.
- Back-to-back writes to the same register: the last writer wins, and each write counts in `instret`.

## Structure
- `defines.vh` gains the following constants:
  - `REG_SRC_ALU` 2'b00, `REG_SRC_MEM` 2'b01, `REG_SRC_JAL` 2'b10, `REG_SRC_RSVD` 2'b11.
  - Existing `WORD_WIDTH`, `REG_SIZE`, `REG_SRC_LENGTH` and `ZERO_WORD` are reused.
- Sub-module `wb_mux` holds the combinational source select and the `commitW` decode. The top level holds storage, bypass, counter and trace.
- The storage array is synthesised as flops, because asynchronous clear is required.

## Test plan
- Reset, then write x5 = 0x12345678 with source 00 -> `rs_dataD` with x5 reads 0x12345678 the same cycle (bypass) and after the edge. `instret` = 1, `trace_we` = 1, `trace_addr` = 5.
- Write x0 = 0xFFFFFFFF with `Regfile_weW` = 1 -> x0 reads 0, `commitW` = 0, and `instret` is unchanged.
- Source 01 (`readDataW` 0xCAFEBABE) to x7, source 10 (`jal_targetW` 0x00400010) to x31, then source 11 to x8 -> x7 = 0xCAFEBABE, x31 = 0x00400010, x8 = 0. `instret` increments by exactly 2.
- Write x9 = 1 then x9 = 2 on consecutive cycles, with rs = rt = 9 -> both ports read 1 and then 2 in the respective cycles. Final x9 = 2.
- Preload `instret` near wrap (0xFFFFFFFE) via 2 commits after forcing -> reads 0xFFFFFFFF and then 0.
- Assert `rst` mid-cycle during a pending commit to x3 -> x3 = 0 and `instret` = 0 immediately. No write occurs at the following edge.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the write-back stage and register file.
package wb_regfile_pkg;

    localparam int unsigned WORD_WIDTH     = 32;
    localparam int unsigned REG_SIZE       = 5;
    localparam int unsigned REG_SRC_LENGTH = 2;

    typedef logic [WORD_WIDTH-1:0] word_t;
    typedef logic [REG_SIZE-1:0]   reg_addr_t;

    localparam word_t ZERO_WORD = '0;

    // Write-back source select encoding.
    typedef enum logic [REG_SRC_LENGTH-1:0] {
        REG_SRC_ALU  = 2'b00,
        REG_SRC_MEM  = 2'b01,
        REG_SRC_JAL  = 2'b10,
        REG_SRC_RSVD = 2'b11
    } reg_src_e;

endpackage

// File: rtl/wb_regfile_if.sv
// W-stage bundle, decode read ports and trace outputs of the register file.
interface wb_regfile_if;
    import wb_regfile_pkg::*;

    logic                      Regfile_weW;
    logic [REG_SRC_LENGTH-1:0] regSrc_muxW;
    word_t                     aluOutW;
    word_t                     readDataW;
    word_t                     jal_targetW;
    reg_addr_t                 writeRegAddrW;
    reg_addr_t                 rs_addrD;
    reg_addr_t                 rt_addrD;
    word_t                     rs_dataD;
    word_t                     rt_dataD;
    word_t                     wb_dataW;
    logic                      commitW;
    word_t                     instret;
    logic                      trace_we;
    reg_addr_t                 trace_addr;
    word_t                     trace_data;

    modport master (
        output Regfile_weW, regSrc_muxW, aluOutW, readDataW, jal_targetW,
               writeRegAddrW, rs_addrD, rt_addrD,
        input  rs_dataD, rt_dataD, wb_dataW, commitW, instret,
               trace_we, trace_addr, trace_data
    );

    modport slave (
        input  Regfile_weW, regSrc_muxW, aluOutW, readDataW, jal_targetW,
               writeRegAddrW, rs_addrD, rt_addrD,
        output rs_dataD, rt_dataD, wb_dataW, commitW, instret,
               trace_we, trace_addr, trace_data
    );

endinterface

// File: rtl/wb_regfile_wb_mux.sv
// Write-back source select and commit decode.
module wb_mux
    import wb_regfile_pkg::*;
(
    input  logic                      Regfile_weW,
    input  logic [REG_SRC_LENGTH-1:0] regSrc_muxW,
    input  word_t                     aluOutW,
    input  word_t                     readDataW,
    input  word_t                     jal_targetW,
    input  reg_addr_t                 writeRegAddrW,
    output word_t                     wb_dataW,
    output logic                      commitW
);

    // Pick the write-back value; the reserved code yields zero and never commits.
    always_comb begin
        wb_dataW = ZERO_WORD;
        commitW  = 1'b0;
        unique case (reg_src_e'(regSrc_muxW))
            REG_SRC_ALU:  wb_dataW = aluOutW;
            REG_SRC_MEM:  wb_dataW = readDataW;
            REG_SRC_JAL:  wb_dataW = jal_targetW;
            REG_SRC_RSVD: wb_dataW = ZERO_WORD;
            default:      wb_dataW = ZERO_WORD;
        endcase
        commitW = Regfile_weW && (writeRegAddrW != '0) &&
                  (reg_src_e'(regSrc_muxW) != REG_SRC_RSVD);
    end

endmodule

// File: rtl/wb_regfile.sv
// Register file with write-first bypass, commit counter and trace port.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int unsigned NREGS    = 32,
    parameter bit          TRACE_EN = 1'b1
) (
    input logic         clk,
    input logic         rst,
    wb_regfile_if.slave bus
);

    word_t wb_data;
    logic  commit;
    word_t instret_q;

    // Register 0 has no storage; it is decoded as constant zero on read.
    word_t regs [1:NREGS-1];

    wb_mux u_wb_mux (
        .Regfile_weW   (bus.Regfile_weW),
        .regSrc_muxW   (bus.regSrc_muxW),
        .aluOutW       (bus.aluOutW),
        .readDataW     (bus.readDataW),
        .jal_targetW   (bus.jal_targetW),
        .writeRegAddrW (bus.writeRegAddrW),
        .wb_dataW      (wb_data),
        .commitW       (commit)
    );

    assign bus.wb_dataW = wb_data;
    assign bus.commitW  = commit;
    assign bus.instret  = instret_q;

    // Storage: flops with asynchronous clear, updated on commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 1; i < NREGS; i++) regs[i] <= ZERO_WORD;
        end else if (commit) begin
            for (int unsigned i = 1; i < NREGS; i++)
                if (bus.writeRegAddrW == REG_SIZE'(i)) regs[i] <= wb_data;
        end
    end

    // rs read port: zero register, then write-first bypass, then storage.
    always_comb begin
        bus.rs_dataD = ZERO_WORD;
        if (bus.rs_addrD != '0) begin
            if (commit && (bus.rs_addrD == bus.writeRegAddrW)) begin
                bus.rs_dataD = wb_data;
            end else begin
                for (int unsigned i = 1; i < NREGS; i++)
                    if (bus.rs_addrD == REG_SIZE'(i)) bus.rs_dataD = regs[i];
            end
        end
    end

    // rt read port: same priority as rs, bypassing independently.
    always_comb begin
        bus.rt_dataD = ZERO_WORD;
        if (bus.rt_addrD != '0) begin
            if (commit && (bus.rt_addrD == bus.writeRegAddrW)) begin
                bus.rt_dataD = wb_data;
            end else begin
                for (int unsigned i = 1; i < NREGS; i++)
                    if (bus.rt_addrD == REG_SIZE'(i)) bus.rt_dataD = regs[i];
            end
        end
    end

    // Committed-write counter, wraps silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        instret_q <= '0;
        else if (commit) instret_q <= instret_q + 32'd1;
    end

    generate
        if (TRACE_EN) begin : g_trace
            logic      trace_we_q;
            reg_addr_t trace_addr_q;
            word_t     trace_data_q;

            // Trace strobe follows every cycle; address/data hold between commits.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    trace_we_q   <= 1'b0;
                    trace_addr_q <= '0;
                    trace_data_q <= '0;
                end else begin
                    trace_we_q <= commit;
                    if (commit) begin
                        trace_addr_q <= bus.writeRegAddrW;
                        trace_data_q <= wb_data;
                    end
                end
            end

            assign bus.trace_we   = trace_we_q;
            assign bus.trace_addr = trace_addr_q;
            assign bus.trace_data = trace_data_q;
        end else begin : g_no_trace
            assign bus.trace_we   = 1'b0;
            assign bus.trace_addr = '0;
            assign bus.trace_data = '0;
        end
    endgenerate

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: expectations queued at drive time, checked on sample.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    wb_regfile_if bus();

    wb_regfile #(.NREGS(32), .TRACE_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum int unsigned {
        K_RS, K_RT, K_WB, K_COMMIT, K_INSTRET, K_TWE, K_TADDR, K_TDATA
    } kind_e;

    typedef struct {
        string       tag;
        kind_e       kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    int unsigned n_tests  = 0;
    int unsigned n_failed = 0;

    logic [31:0] mdl_regs [32];
    logic [31:0] mdl_instret;
    logic        mdl_twe;
    logic [4:0]  mdl_taddr;
    logic [31:0] mdl_tdata;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] observe(input kind_e k);
        case (k)
            K_RS:      return bus.rs_dataD;
            K_RT:      return bus.rt_dataD;
            K_WB:      return bus.wb_dataW;
            K_COMMIT:  return {31'd0, bus.commitW};
            K_INSTRET: return bus.instret;
            K_TWE:     return {31'd0, bus.trace_we};
            K_TADDR:   return {27'd0, bus.trace_addr};
            default:   return bus.trace_data;
        endcase
    endfunction

    task automatic expect_val(input string tag, input kind_e k, input logic [31:0] e);
        exp_t x;
        x.tag  = tag;
        x.kind = k;
        x.exp  = e;
        sb.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            check_eq(x.tag, observe(x.kind), x.exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl_regs[i] = '0;
        mdl_instret = '0;
        mdl_twe     = 1'b0;
        mdl_taddr   = '0;
        mdl_tdata   = '0;
    endtask

    task automatic drive(input logic we, input logic [1:0] src, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] jal,
                         input logic [4:0] waddr, input logic [4:0] rs, input logic [4:0] rt);
        bus.Regfile_weW   = we;
        bus.regSrc_muxW   = src;
        bus.aluOutW       = alu;
        bus.readDataW     = mem;
        bus.jal_targetW   = jal;
        bus.writeRegAddrW = waddr;
        bus.rs_addrD      = rs;
        bus.rt_addrD      = rt;
    endtask

    task automatic expect_seq(input string tag);
        expect_val({tag, ".instret"}, K_INSTRET, mdl_instret);
        expect_val({tag, ".trace_we"}, K_TWE, {31'd0, mdl_twe});
        expect_val({tag, ".trace_addr"}, K_TADDR, {27'd0, mdl_taddr});
        expect_val({tag, ".trace_data"}, K_TDATA, mdl_tdata);
    endtask

    // One full cycle: combinational checks before the edge, state checks after it.
    task automatic step(input string tag, input logic we, input logic [1:0] src,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] jal,
                        input logic [4:0] waddr, input logic [4:0] rs, input logic [4:0] rt);
        logic [31:0] e_wb;
        logic        e_c;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        @(negedge clk);
        drive(we, src, alu, mem, jal, waddr, rs, rt);
        #1;
        case (src)
            2'b00:   e_wb = alu;
            2'b01:   e_wb = mem;
            2'b10:   e_wb = jal;
            default: e_wb = 32'd0;
        endcase
        e_c  = we && (waddr != 5'd0) && (src != 2'b11);
        e_rs = (rs == 5'd0) ? 32'd0 : ((e_c && rs == waddr) ? e_wb : mdl_regs[rs]);
        e_rt = (rt == 5'd0) ? 32'd0 : ((e_c && rt == waddr) ? e_wb : mdl_regs[rt]);
        expect_val({tag, ".rs"}, K_RS, e_rs);
        expect_val({tag, ".rt"}, K_RT, e_rt);
        expect_val({tag, ".wb"}, K_WB, e_wb);
        expect_val({tag, ".commit"}, K_COMMIT, {31'd0, e_c});
        drain();
        @(posedge clk);
        if (e_c) begin
            mdl_regs[waddr] = e_wb;
            mdl_instret     = mdl_instret + 32'd1;
            mdl_taddr       = waddr;
            mdl_tdata       = e_wb;
        end
        mdl_twe = e_c;
        #1;
        expect_seq(tag);
        drain();
    endtask

    initial begin
        model_reset();
        drive(1'b0, 2'b00, '0, '0, '0, 5'd0, 5'd5, 5'd0);
        #2;
        expect_val("reset.rs", K_RS, 32'd0);
        expect_seq("reset");
        drain();
        @(negedge clk);
        rst = 1'b1;

        // Basic ALU write with bypass, then read back from storage.
        step("x5_wr", 1'b1, 2'b00, 32'h12345678, 32'h0, 32'h0, 5'd5, 5'd5, 5'd0);
        step("x5_rd", 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);

        // Write to x0 is dropped.
        step("x0_wr", 1'b1, 2'b00, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

        // Each source, then reserved source.
        step("x7_mem", 1'b1, 2'b01, 32'h1111, 32'hCAFEBABE, 32'h2222, 5'd7, 5'd7, 5'd5);
        step("x31_jal", 1'b1, 2'b10, 32'h1111, 32'h3333, 32'h00400010, 5'd31, 5'd7, 5'd31);
        step("x8_rsvd", 1'b1, 2'b11, 32'h1111, 32'h3333, 32'h4444, 5'd8, 5'd8, 5'd31);
        step("src_rd", 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd8);

        // Back-to-back writes to the same register with rs == rt.
        step("x9_a", 1'b1, 2'b00, 32'd1, 32'h0, 32'h0, 5'd9, 5'd9, 5'd9);
        step("x9_b", 1'b1, 2'b00, 32'd2, 32'h0, 32'h0, 5'd9, 5'd9, 5'd9);
        step("x9_rd", 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9);

        // Counter wrap from a preloaded value.
        @(negedge clk);
        force dut.instret_q = 32'hFFFFFFFE;
        #1;
        release dut.instret_q;
        mdl_instret = 32'hFFFFFFFE;
        expect_val("wrap.preload", K_INSTRET, mdl_instret);
        drain();
        step("wrap_a", 1'b1, 2'b00, 32'hA, 32'h0, 32'h0, 5'd10, 5'd10, 5'd0);
        step("wrap_b", 1'b1, 2'b00, 32'hB, 32'h0, 32'h0, 5'd11, 5'd10, 5'd11);

        // Mixed traffic.
        for (int i = 0; i < 24; i++) begin
            logic [4:0] wa;
            logic [4:0] ra;
            wa = 5'($urandom_range(0, 31));
            ra = (i % 3 == 0) ? wa : 5'($urandom_range(0, 31));
            step("mix", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 $urandom, $urandom, $urandom, wa, ra, 5'($urandom_range(0, 31)));
        end

        // Reset asserted while a commit to x3 is pending.
        step("x3_pre", 1'b1, 2'b00, 32'h33, 32'h0, 32'h0, 5'd3, 5'd3, 5'd0);
        @(negedge clk);
        drive(1'b1, 2'b00, 32'hDEADBEEF, 32'h0, 32'h0, 5'd3, 5'd3, 5'd3);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        bus.Regfile_weW = 1'b0;
        #1;
        expect_val("rst_mid.rs", K_RS, 32'd0);
        expect_val("rst_mid.rt", K_RT, 32'd0);
        expect_seq("rst_mid");
        drain();
        bus.Regfile_weW = 1'b1;
        @(posedge clk);
        #1;
        expect_seq("rst_edge");
        drain();
        @(negedge clk);
        bus.Regfile_weW = 1'b0;
        #1;
        expect_val("rst_edge.x3", K_RS, 32'd0);
        drain();
        rst = 1'b1;

        // First edge after reset release commits normally.
        step("post_rst", 1'b1, 2'b00, 32'h55AA55AA, 32'h0, 32'h0, 5'd3, 5'd3, 5'd0);
        step("post_rd", 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
